// File: rtl/hba_arbiter.sv
// Round-robin arbiter for the shared HBA slave bus, with a per-transfer watchdog
// that injects a synthetic acknowledge when no slave answers in time.
module hba_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_BURST      = 4
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset_n,
  input  logic [NUM_MASTERS-1:0] hba_mreq,
  input  logic                   hba_select,
  input  logic                   hba_xferack,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic                   hba_xferack_out,
  output logic                   hba_timeout,
  output logic [7:0]             hba_timeout_cnt,
  output logic                   hba_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_XFER    = 3'd2,
    S_TOUT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_last_grant;
  logic [3:0]             r_burst_cnt;
  logic [7:0]             r_xfer_cnt;
  logic [7:0]             r_timeout_cnt;
  logic [NUM_MASTERS-1:0] r_mgrant;
  logic                   r_timeout;
  logic                   r_busy;

  logic [7:0]             w_mreq8;
  logic [3:0]             w_pick;
  logic                   w_req_held;
  logic [3:0]             w_burst_inc;
  logic                   w_done_release;
  logic                   w_complete;
  logic                   w_wd_expired;
  logic [2:0]             w_last_grant_d;
  logic [NUM_MASTERS-1:0] w_mgrant_d;
  logic                   w_timeout_d;
  logic                   w_busy_d;

  // Returns {valid, index} of the first requester scanning upward from last+1.
  // Iterating downward lets the nearest candidate overwrite the farther ones.
  function automatic logic [3:0] rr_pick(input logic [2:0] last, input logic [7:0] req);
    logic [3:0] sum;
    logic [3:0] res;
    res = {1'b0, last};
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      sum = {1'b0, last} + 4'(i);
      if (sum >= 4'(NUM_MASTERS)) begin
        sum = sum - 4'(NUM_MASTERS);
      end else begin
        sum = sum;
      end
      if (req[sum[2:0]]) begin
        res = {1'b1, sum[2:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_mreq8        = 8'(hba_mreq);
  assign w_pick         = rr_pick(r_last_grant, w_mreq8);
  assign w_req_held     = w_mreq8[r_last_grant];
  assign w_burst_inc    = r_burst_cnt + 4'd1;
  assign w_done_release = !w_req_held || (w_burst_inc == 4'(MAX_BURST));
  assign w_wd_expired   = (r_xfer_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_complete     = ((r_state == S_XFER) && hba_xferack) || (r_state == S_TOUT);

  // State register.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a slave ack takes priority over watchdog expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick[3]) w_next_state = S_GRANT;
        else           w_next_state = S_IDLE;
      end
      S_GRANT: begin
        if (hba_select)       w_next_state = S_XFER;
        else if (!w_req_held) w_next_state = S_RELEASE;
        else                  w_next_state = S_GRANT;
      end
      S_XFER: begin
        if (hba_xferack)       w_next_state = w_done_release ? S_RELEASE : S_GRANT;
        else if (w_wd_expired) w_next_state = S_TOUT;
        else                   w_next_state = S_XFER;
      end
      S_TOUT:    w_next_state = w_done_release ? S_RELEASE : S_GRANT;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every output leaves a flop.
  always_comb begin
    w_last_grant_d = r_last_grant;
    if ((r_state == S_IDLE) && w_pick[3]) begin
      w_last_grant_d = w_pick[2:0];
    end else begin
      w_last_grant_d = r_last_grant;
    end
    w_mgrant_d = '0;
    case (w_next_state)
      S_GRANT, S_XFER, S_TOUT: w_mgrant_d = NUM_MASTERS'(1) << w_last_grant_d;
      default:                 w_mgrant_d = '0;
    endcase
    w_timeout_d = (w_next_state == S_TOUT);
    w_busy_d    = (w_next_state != S_IDLE);
  end

  // Counters and registered outputs.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_last_grant  <= 3'(NUM_MASTERS - 1);
      r_burst_cnt   <= 4'd0;
      r_xfer_cnt    <= 8'd0;
      r_timeout_cnt <= 8'd0;
      r_mgrant      <= '0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_last_grant <= w_last_grant_d;
      if ((r_state == S_IDLE) && w_pick[3]) begin
        r_burst_cnt <= 4'd0;
      end else if (w_complete) begin
        r_burst_cnt <= w_burst_inc;
      end
      if ((r_state == S_GRANT) && hba_select) begin
        r_xfer_cnt <= 8'd0;
      end else if ((r_state == S_XFER) && !hba_xferack && !w_wd_expired) begin
        r_xfer_cnt <= r_xfer_cnt + 8'd1;
      end
      if (w_timeout_d && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
      r_mgrant  <= w_mgrant_d;
      r_timeout <= w_timeout_d;
      r_busy    <= w_busy_d;
    end
  end

  assign hba_mgrant      = r_mgrant;
  assign hba_timeout     = r_timeout;
  assign hba_timeout_cnt = r_timeout_cnt;
  assign hba_busy        = r_busy;
  assign hba_xferack_out = hba_xferack | r_timeout;

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed, table-driven bench for hba_arbiter: inputs are driven on the falling
// edge and outputs checked 1 time unit later, one table row per clock cycle.
module tb_hba_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mreq = 4'b0000;
  logic       sel = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] grant;
  logic       ack_out;
  logic       tout;
  logic [7:0] tcnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [3:0] exp_g;

  typedef struct {
    logic [3:0] mreq;
    logic       sel;
    logic       ack;
    logic [3:0] grant;
    logic       ao;
    logic       to;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[12];

  hba_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(16), .MAX_BURST(4)) dut (
    .hba_clk(clk), .hba_reset_n(rst_n), .hba_mreq(mreq), .hba_select(sel),
    .hba_xferack(ack), .hba_mgrant(grant), .hba_xferack_out(ack_out),
    .hba_timeout(tout), .hba_timeout_cnt(tcnt), .hba_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic s, input logic a);
    @(negedge clk);
    mreq = m; sel = s; ack = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mreq = 4'b0000; sel = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // single transfer, ack in 3rd XFER cycle, stray acks, release
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0};

    // reset state
    ack = 1'b1;
    #12;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tout", tout, 1'b0);
    chk("rst_cnt", tcnt, 8'd0);
    chk("rst_ack_follow_hi", ack_out, 1'b1);
    ack = 1'b0;
    #1;
    chk("rst_ack_follow_lo", ack_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].mreq, tbl[i].sel, tbl[i].ack);
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("vec%0d_ackout", i), ack_out, tbl[i].ao);
      chk($sformatf("vec%0d_tout", i), tout, tbl[i].to);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_cnt", i), tcnt, tbl[i].cnt);
    end

    // round robin with full bursts
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1 << (k % 4));
      drive(4'hF, 1'b0, 1'b0);
      chk($sformatf("rr%0d_idle_grant", k), grant, 4'b0000);
      for (int t = 0; t < 4; t++) begin
        if (t > 0) begin
          drive(4'hF, 1'b0, 1'b0);
          chk($sformatf("rr%0d_hold%0d", k, t), grant, exp_g);
        end
        drive(4'hF, 1'b1, 1'b0);
        chk($sformatf("rr%0d_grant%0d", k, t), grant, exp_g);
        drive(4'hF, 1'b1, 1'b1);
        chk($sformatf("rr%0d_xfer%0d", k, t), grant, exp_g);
        chk($sformatf("rr%0d_ack%0d", k, t), ack_out, 1'b1);
      end
      drive(4'hF, 1'b0, 1'b0);
      chk($sformatf("rr%0d_release_grant", k), grant, 4'b0000);
      chk($sformatf("rr%0d_release_busy", k), busy, 1'b1);
    end

    // watchdog expiry exactly 16 cycles after select is sampled
    do_reset();
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    chk("wd_grant", grant, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      drive(4'b0001, 1'b1, 1'b0);
      chk($sformatf("wd_xfer%0d_tout", i), tout, 1'b0);
      chk($sformatf("wd_xfer%0d_ack", i), ack_out, 1'b0);
    end
    drive(4'b0001, 1'b1, 1'b0);
    chk("wd_tout_pulse", tout, 1'b1);
    chk("wd_tout_ack", ack_out, 1'b1);
    drive(4'b0001, 1'b0, 1'b0);
    chk("wd_after_tout", tout, 1'b0);
    chk("wd_after_ack", ack_out, 1'b0);
    chk("wd_cnt1", tcnt, 8'd1);
    chk("wd_after_grant", grant, 4'b0001);

    // saturation of the expiry counter
    pulses = 1;
    for (int c = 0; c < 20000 && pulses < 300; c++) begin
      drive(4'b0001, 1'b1, 1'b0);
      if (tout) begin
        pulses++;
        if (pulses == 100 || pulses == 255 || pulses == 300) begin
          drive(4'b0001, 1'b1, 1'b0);
          chk($sformatf("sat_cnt_at_%0d", pulses), tcnt, (pulses > 255) ? 8'd255 : 8'(pulses));
        end
      end
    end
    chk("sat_pulses_seen", pulses, 300);

    // ack in the same cycle the watchdog would expire
    do_reset();
    drive(4'b0001, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b1);
    chk("lim_ack_out", ack_out, 1'b1);
    chk("lim_no_tout", tout, 1'b0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("lim_after_tout", tout, 1'b0);
    chk("lim_after_grant", grant, 4'b0001);
    chk("lim_after_cnt", tcnt, 8'd0);
    drive(4'b0001, 1'b0, 1'b0);
    chk("lim_after2_tout", tout, 1'b0);

    // master 2 drops its request mid transfer
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    chk("drop_grant", grant, 4'b0100);
    drive(4'b1000, 1'b1, 1'b0);
    chk("drop_xfer1", grant, 4'b0100);
    drive(4'b1000, 1'b1, 1'b0);
    chk("drop_xfer2", grant, 4'b0100);
    chk("drop_xfer2_busy", busy, 1'b1);
    drive(4'b1000, 1'b1, 1'b1);
    chk("drop_ack", ack_out, 1'b1);
    chk("drop_ack_grant", grant, 4'b0100);
    drive(4'b1000, 1'b0, 1'b0);
    chk("drop_release", grant, 4'b0000);
    chk("drop_release_busy", busy, 1'b1);
    drive(4'b1000, 1'b0, 1'b0);
    chk("drop_idle", grant, 4'b0000);
    chk("drop_idle_busy", busy, 1'b0);
    drive(4'b1000, 1'b0, 1'b0);
    chk("drop_next_owner", grant, 4'b1000);

    // asynchronous reset in the middle of a transfer
    do_reset();
    pulses = 0;
    for (int c = 0; c < 500 && pulses < 5; c++) begin
      drive(4'b0001, 1'b1, 1'b0);
      if (tout) pulses++;
    end
    chk("prerst_pulses", pulses, 5);
    drive(4'b0001, 1'b1, 1'b0);
    drive(4'b0001, 1'b1, 1'b0);
    chk("prerst_cnt", tcnt, 8'd5);
    chk("prerst_busy", busy, 1'b1);
    chk("prerst_grant", grant, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cnt", tcnt, 8'd0);
    chk("arst_tout", tout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; mreq = 4'b0011; sel = 1'b0;
    drive(4'b0011, 1'b0, 1'b0);
    chk("post_rst_master0_wins", grant, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hba_arbiter.md
# hba_arbiter

Round-robin arbiter and transfer watchdog for the HBA bus. It shares the single HBA slave bus between up to NUM_MASTERS requesters by issuing one-hot grants, and monitors each transfer started by the granted master. If the ORed slave acknowledge does not arrive within TIMEOUT_CYCLES, it injects a synthetic acknowledge, so that an unmapped address cannot hang a master. The block sits beside the slave-output OR tree, and the top level uses its grant vector to steer the master-side address/data/select mux.

## Interface
- NUM_MASTERS, 4: number of requesters, legal range 2..8.
- TIMEOUT_CYCLES, 16: XFER cycles without ack before a synthetic ack, legal range 2..255.
- MAX_BURST, 4: completed transfers per grant before forced release, legal range 1..15.

- hba_clk  input  1  bus clock; all state changes on rising edge.
- hba_reset_n  input  1  asynchronous, active-low reset.
- hba_mreq  input  NUM_MASTERS  per-master bus request; held high while the master wants the bus.
- hba_select  input  1  select of the currently granted master, from the master mux.
- hba_xferack  input  1  ORed slave acknowledge.
- hba_mgrant  output  NUM_MASTERS  one-hot (or zero) registered grant.
- hba_xferack_out  output  1  acknowledge to masters: hba_xferack OR synthetic ack.
- hba_timeout  output  1  one-cycle pulse per watchdog expiry.
- hba_timeout_cnt  output  8  saturating count of watchdog expiries.
- hba_busy  output  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: grant 0.
  - GRANT: grant held, waiting for select.
  - XFER: transfer in progress.
  - TOUT: synthetic ack cycle.
  - RELEASE: grant 0 for one dead cycle.
- IDLE: if any hba_mreq is set, pick the first requester scanning upward (modulo NUM_MASTERS) from last_grant+1.
  - Load the one-hot grant, store the index in last_grant, clear burst_cnt, go to GRANT.
  - If no request, stay in IDLE.
- GRANT:
  - hba_select high: go to XFER and clear xfer_cnt.
  - Else, requester's hba_mreq low: go to RELEASE.
  - Else stay in GRANT.
  - Requests from other masters are ignored.
- XFER:
  - hba_xferack high: completion.
  - Else xfer_cnt==TIMEOUT_CYCLES-1: go to TOUT.
  - Else increment xfer_cnt.
  - hba_mreq is ignored in XFER; a dropped request never aborts a transfer.
- TOUT: lasts one cycle, then completion.
  - hba_xferack_out=1 and hba_timeout=1.
  - hba_timeout_cnt increments, saturating at 255.
- Completion (from XFER or TOUT):
  - burst_cnt increments.
  - If the requester's hba_mreq is low, or the new burst_cnt==MAX_BURST: go to RELEASE.
  - Else go to GRANT.
- RELEASE: go to IDLE unconditionally. The grant is zero for at least two cycles between owners (RELEASE then IDLE), which guarantees mux turnaround.
- Master contract: the master deasserts hba_select in the cycle after it sees hba_xferack_out. A select seen high in GRANT always starts a new transfer.
- Arithmetic: xfer_cnt is 8 bits, burst_cnt is 4 bits, last_grant is 3 bits; none of them can wrap within the legal parameter ranges.
- hba_xferack_out = hba_xferack | (state==TOUT), combinational. A stray slave ack outside XFER is passed through and does not change state.

## Timing
- Reset values:
  - hba_mgrant=0, hba_timeout=0, hba_timeout_cnt=0, hba_busy=0.
  - hba_xferack_out follows hba_xferack.
  - state=IDLE, last_grant=NUM_MASTERS-1, so master 0 wins first.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronous). hba_timeout_cnt is cleared as well.
- Request latency: request high before edge N while in IDLE gives grant visible after edge N.
- Transfer: select high in GRANT at edge S gives XFER from S.
  - A slave ack in the first XFER cycle is sampled at S+1 and the state returns to GRANT.
  - With no ack, TOUT occupies cycle S+TIMEOUT_CYCLES; hba_xferack_out is high only in that cycle.
- Ack and watchdog expiry in the same cycle: the ack wins. No TOUT state and no hba_timeout pulse.
- Requester drops hba_mreq in the same cycle an ack arrives: go to RELEASE.

## Test plan
- Reset, then hba_mreq=4'b0001 -> grant 4'b0001 one cycle later. Select high, ack on the 3rd XFER cycle -> hba_xferack_out high that cycle only; hba_timeout_cnt stays 0.
- hba_mreq=4'b1111 held, each master doing single-ack transfers -> grants in order 0001, 0010, 0100, 1000, 0001. Each owner keeps the grant for exactly MAX_BURST=4 transfers, with two zero-grant cycles between owners.
- Select held with no slave ack, TIMEOUT_CYCLES=16 -> hba_xferack_out and hba_timeout high exactly 16 cycles after select is sampled; hba_timeout_cnt=1. Force 300 timeouts -> hba_timeout_cnt stays at 255.
- Ack on the same cycle xfer_cnt reaches 15 -> no hba_timeout pulse, count unchanged.
- Master 2 drops hba_mreq mid-XFER -> transfer completes on ack, then RELEASE; next requester master 3 is granted 2 cycles after the ack.
- hba_reset_n pulsed low during XFER with hba_timeout_cnt=5 -> grant, busy and count go to 0 immediately. After release, a request from master 1 with master 0 also requesting -> master 0 is granted.
